// File: rtl/axil_rr_arbiter.sv
// Two-requester round-robin arbiter that turns simple REQ/ACK transfers into single
// AXI4-Lite master transactions, one at a time.
module axil_rr_arbiter #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            REQ0,
  input  logic                            REQ1,
  input  logic                            WE0,
  input  logic                            WE1,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   ADDR0,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   ADDR1,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   WDATA0,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   WDATA1,
  output logic                            ACK0,
  output logic                            ACK1,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   RDATA0,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   RDATA1,
  output logic [1:0]                      RESP0,
  output logic [1:0]                      RESP1,
  output logic                            ERR,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_M_AXI_DATA_WIDTH;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWaddr = 3'd1;
  localparam logic [2:0] StWresp = 3'd2;
  localparam logic [2:0] StRaddr = 3'd3;
  localparam logic [2:0] StRresp = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic          last_q, last_d;
  logic          gnt_q, gnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          bready_q, bready_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic [1:0]    resp0_q, resp0_d;
  logic [1:0]    resp1_q, resp1_d;
  logic          err_q, err_d;
  logic          sel, sel_we, aw_pend, w_pend;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    resp0_d   = resp0_q;
    resp1_d   = resp1_q;
    err_d     = err_q;
    // Under contention the requester that did not win last time gets the grant.
    sel       = (REQ0 && REQ1) ? ~last_q : REQ1;
    sel_we    = sel ? WE1 : WE0;
    aw_pend   = awvalid_q && !M_AXI_AWREADY;
    w_pend    = wvalid_q && !M_AXI_WREADY;

    unique case (state_q)
      StIdle: begin
        if (REQ0 || REQ1) begin
          gnt_d   = sel;
          last_d  = sel;
          addr_d  = sel ? ADDR1 : ADDR0;
          wdata_d = sel ? WDATA1 : WDATA0;
          if (sel_we) begin
            state_d   = StWaddr;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = StRaddr;
            arvalid_d = 1'b1;
          end
        end
      end
      StWaddr: begin
        awvalid_d = aw_pend;
        wvalid_d  = w_pend;
        if (!aw_pend && !w_pend) begin
          state_d  = StWresp;
          bready_d = 1'b1;
        end
      end
      StWresp: begin
        if (M_AXI_BVALID) begin
          state_d  = StDone;
          bready_d = 1'b0;
          err_d    = err_q || (M_AXI_BRESP != 2'b00);
          if (gnt_q) begin
            ack1_d  = 1'b1;
            resp1_d = M_AXI_BRESP;
          end else begin
            ack0_d  = 1'b1;
            resp0_d = M_AXI_BRESP;
          end
        end
      end
      StRaddr: begin
        if (M_AXI_ARREADY) begin
          state_d   = StRresp;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      StRresp: begin
        if (M_AXI_RVALID) begin
          state_d  = StDone;
          rready_d = 1'b0;
          err_d    = err_q || (M_AXI_RRESP != 2'b00);
          if (gnt_q) begin
            ack1_d   = 1'b1;
            rdata1_d = M_AXI_RDATA;
            resp1_d  = M_AXI_RRESP;
          end else begin
            ack0_d   = 1'b1;
            rdata0_d = M_AXI_RDATA;
            resp0_d  = M_AXI_RRESP;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      resp0_q   <= 2'b00;
      resp1_q   <= 2'b00;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      resp0_q   <= resp0_d;
      resp1_q   <= resp1_d;
      err_q     <= err_d;
    end
  end

  assign ACK0          = ack0_q;
  assign ACK1          = ack1_q;
  assign RDATA0        = rdata0_q;
  assign RDATA1        = rdata1_q;
  assign RESP0         = resp0_q;
  assign RESP1         = resp1_q;
  assign ERR           = err_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// Directed bench for axil_rr_arbiter with a small AXI4-Lite slave model that returns
// each response one cycle after the address/data are accepted.
module tb_axil_rr_arbiter;

  logic        tb_ACLK = 1'b0;
  logic        tb_ARESETN = 1'b0;
  logic        REQ0 = 1'b0, REQ1 = 1'b0, WE0 = 1'b0, WE1 = 1'b0;
  logic [31:0] ADDR0 = '0, ADDR1 = '0, WDATA0 = '0, WDATA1 = '0;
  logic        ACK0, ACK1, ERR;
  logic [31:0] RDATA0, RDATA1;
  logic [1:0]  RESP0, RESP1;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;

  int errors = 0;
  int checks = 0;

  // Slave model configuration and state
  int          aw_delay = 0;
  int          aw_cnt = 0;
  logic        b_hold = 1'b0;
  logic        rnd = 1'b0;
  logic [1:0]  rresp_cfg = 2'b00;
  logic        rd_fixed_en = 1'b0;
  logic [31:0] rd_fixed = 32'h0;
  logic        aw_got, w_got, b_pend, r_pend, ar_rdy;
  logic [31:0] r_addr;

  int          aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0, ar_hs_cnt = 0, stab_err = 0;
  logic [31:0] last_awaddr = '0;
  logic [3:0]  last_wstrb = '0;
  logic        pend_aw_q = 1'b0, pend_w_q = 1'b0, pend_ar_q = 1'b0;
  logic [31:0] prev_awaddr = '0, prev_wdata = '0, prev_araddr = '0;

  wire aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  wire w_hs  = M_AXI_WVALID && M_AXI_WREADY;
  wire b_hs  = M_AXI_BVALID && M_AXI_BREADY;
  wire ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
  wire r_hs  = M_AXI_RVALID && M_AXI_RREADY;

  assign M_AXI_AWREADY = (aw_cnt >= aw_delay);
  assign M_AXI_WREADY  = 1'b1;
  assign M_AXI_BRESP   = 2'b00;
  assign M_AXI_RRESP   = rresp_cfg;
  assign M_AXI_ARREADY = ar_rdy;

  axil_rr_arbiter #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(32)
  ) dut (
    .ACLK(tb_ACLK), .ARESETN(tb_ARESETN),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .ACK0(ACK0), .ACK1(ACK1), .RDATA0(RDATA0), .RDATA1(RDATA1),
    .RESP0(RESP0), .RESP1(RESP1), .ERR(ERR),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 tb_ACLK = ~tb_ACLK;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  always @(posedge tb_ACLK or negedge tb_ARESETN) begin
    if (!tb_ARESETN) begin
      aw_cnt       <= 0;
      aw_got       <= 1'b0;
      w_got        <= 1'b0;
      b_pend       <= 1'b0;
      M_AXI_BVALID <= 1'b0;
      r_pend       <= 1'b0;
      r_addr       <= '0;
      M_AXI_RVALID <= 1'b0;
      M_AXI_RDATA  <= '0;
      ar_rdy       <= 1'b1;
    end else begin
      aw_cnt <= (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_cnt + 1 : 0;
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        b_pend <= 1'b1;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs)  w_got  <= 1'b1;
      end
      if (b_pend && !b_hold) begin
        M_AXI_BVALID <= 1'b1;
        b_pend       <= 1'b0;
      end
      if (b_hs) M_AXI_BVALID <= 1'b0;
      ar_rdy <= rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (ar_hs) begin
        r_pend <= 1'b1;
        r_addr <= M_AXI_ARADDR;
      end
      if (r_pend && (!rnd || $urandom_range(0, 1) == 1)) begin
        M_AXI_RVALID <= 1'b1;
        M_AXI_RDATA  <= rd_fixed_en ? rd_fixed : rd_model(r_addr);
        r_pend       <= 1'b0;
      end
      if (r_hs) M_AXI_RVALID <= 1'b0;
    end
  end

  // Handshake counters and VALID/payload stability monitor
  always @(posedge tb_ACLK) begin
    if (tb_ARESETN) begin
      if (aw_hs) begin
        aw_hs_cnt   <= aw_hs_cnt + 1;
        last_awaddr <= M_AXI_AWADDR;
      end
      if (w_hs) begin
        w_hs_cnt   <= w_hs_cnt + 1;
        last_wstrb <= M_AXI_WSTRB;
      end
      if (b_hs)  b_hs_cnt  <= b_hs_cnt + 1;
      if (ar_hs) ar_hs_cnt <= ar_hs_cnt + 1;
      stab_err <= stab_err
                + int'(pend_aw_q && (!M_AXI_AWVALID || M_AXI_AWADDR !== prev_awaddr))
                + int'(pend_w_q && (!M_AXI_WVALID || M_AXI_WDATA !== prev_wdata))
                + int'(pend_ar_q && (!M_AXI_ARVALID || M_AXI_ARADDR !== prev_araddr));
      pend_aw_q <= M_AXI_AWVALID && !M_AXI_AWREADY;
      pend_w_q  <= M_AXI_WVALID && !M_AXI_WREADY;
      pend_ar_q <= M_AXI_ARVALID && !M_AXI_ARREADY;
    end else begin
      pend_aw_q <= 1'b0;
      pend_w_q  <= 1'b0;
      pend_ar_q <= 1'b0;
    end
    prev_awaddr <= M_AXI_AWADDR;
    prev_wdata  <= M_AXI_WDATA;
    prev_araddr <= M_AXI_ARADDR;
  end

  task automatic cyc();
    @(posedge tb_ACLK);
    #1;
  endtask

  task automatic do_reset();
    tb_ARESETN = 1'b0;
    cyc();
    cyc();
    tb_ARESETN = 1'b1;
  endtask

  task automatic test_reset();
    tb_ARESETN = 1'b0;
    repeat (3) cyc();
    checks++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
         ACK0, ACK1, ERR} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000000", {M_AXI_AWVALID, M_AXI_WVALID,
               M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, ACK0, ACK1, ERR});
    end
    checks++;
    if ({RDATA0, RDATA1, RESP0, RESP1} !== 68'h0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %b %b want all zero", RDATA0, RDATA1, RESP0, RESP1);
    end
    checks++;
    if ({M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB} !== {3'b000, 3'b000, 4'hF}) begin
      errors++;
      $display("FAIL prot_strb: got %b %b %h want 000 000 f", M_AXI_AWPROT, M_AXI_ARPROT,
               M_AXI_WSTRB);
    end
    tb_ARESETN = 1'b1;
    cyc();
  endtask

  task automatic test_single_write();
    int n, a0, w0, b0;
    logic ack1_seen;
    a0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt;
    ack1_seen = 1'b0;
    REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 32'h4; WDATA0 = 32'hABCD_0001;
    cyc();
    n = 1;
    checks++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_AWADDR, M_AXI_WDATA} !==
        {2'b11, 32'h4, 32'hABCD_0001}) begin
      errors++;
      $display("FAIL wr_issue: got v=%b%b addr=%h data=%h want v=11 addr=4 data=abcd0001",
               M_AXI_AWVALID, M_AXI_WVALID, M_AXI_AWADDR, M_AXI_WDATA);
    end
    while (ACK0 !== 1'b1 && n < 20) begin
      cyc();
      n++;
      if (ACK1 === 1'b1) ack1_seen = 1'b1;
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL wr_latency: got %0d cycles want 4", n);
    end
    checks++;
    if (RESP0 !== 2'b00 || ack1_seen) begin
      errors++;
      $display("FAIL wr_resp: got RESP0=%b ack1_seen=%b want 00 0", RESP0, ack1_seen);
    end
    REQ0 = 1'b0;
    cyc();
    checks++;
    if (ACK0 !== 1'b0) begin
      errors++;
      $display("FAIL ack_pulse: got ACK0=%b want 0", ACK0);
    end
    checks++;
    if (aw_hs_cnt - a0 != 1 || w_hs_cnt - w0 != 1 || b_hs_cnt - b0 != 1 ||
        last_awaddr !== 32'h4 || last_wstrb !== 4'hF) begin
      errors++;
      $display("FAIL wr_beats: got aw=%0d w=%0d b=%0d addr=%h strb=%h want 1 1 1 4 f",
               aw_hs_cnt - a0, w_hs_cnt - w0, b_hs_cnt - b0, last_awaddr, last_wstrb);
    end
  endtask

  task automatic test_contention();
    int n, k;
    int order [3];
    logic [31:0] got [3];
    logic [31:0] want [3];
    logic both;
    want[0] = rd_model(32'h10); want[1] = rd_model(32'h20); want[2] = rd_model(32'h14);
    both = 1'b0;
    do_reset();
    REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 32'h10;
    REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 32'h20;
    k = 0; n = 0;
    while (k < 3 && n < 100) begin
      cyc();
      n++;
      if (ACK0 === 1'b1 && ACK1 === 1'b1) both = 1'b1;
      if (ACK0 === 1'b1) begin
        order[k] = 0; got[k] = RDATA0; k++;
        // Requester 0 immediately asks again, so the arbiter sees a second contention
        if (k == 1) ADDR0 = 32'h14;
        else REQ0 = 1'b0;
      end else if (ACK1 === 1'b1) begin
        order[k] = 1; got[k] = RDATA1; k++;
        REQ1 = 1'b0;
      end
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    checks++;
    if (k != 3 || both) begin
      errors++;
      $display("FAIL rr_acks: got %0d acks both=%b want 3 acks both=0", k, both);
    end else begin
      checks++;
      if (order[0] != 0 || order[1] != 1 || order[2] != 0) begin
        errors++;
        $display("FAIL rr_order: got %0d%0d%0d want 010", order[0], order[1], order[2]);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== want[i]) begin
          errors++;
          $display("FAIL rr_rdata%0d: got %h want %h", i, got[i], want[i]);
        end
      end
    end
    cyc();
  endtask

  task automatic test_split_handshake();
    int n, a0, w0, b0;
    a0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt;
    aw_delay = 3;
    REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 32'h8; WDATA0 = 32'h1234_5678;
    cyc();
    checks++;
    if ({M_AXI_AWVALID, M_AXI_WVALID} !== 2'b11) begin
      errors++;
      $display("FAIL split_start: got %b%b want 11", M_AXI_AWVALID, M_AXI_WVALID);
    end
    cyc();
    checks++;
    if ({M_AXI_AWVALID, M_AXI_WVALID} !== 2'b10) begin
      errors++;
      $display("FAIL split_wdrop: got %b%b want 10", M_AXI_AWVALID, M_AXI_WVALID);
    end
    cyc();
    cyc();
    checks++;
    if (M_AXI_AWVALID !== 1'b1 || M_AXI_AWADDR !== 32'h8 || M_AXI_BREADY !== 1'b0) begin
      errors++;
      $display("FAIL split_hold: got awv=%b addr=%h bready=%b want 1 8 0", M_AXI_AWVALID,
               M_AXI_AWADDR, M_AXI_BREADY);
    end
    cyc();
    checks++;
    if (M_AXI_AWVALID !== 1'b0) begin
      errors++;
      $display("FAIL split_awdrop: got %b want 0", M_AXI_AWVALID);
    end
    n = 0;
    while (ACK0 !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (ACK0 !== 1'b1 || aw_hs_cnt - a0 != 1 || w_hs_cnt - w0 != 1 || b_hs_cnt - b0 != 1 ||
        stab_err != 0) begin
      errors++;
      $display("FAIL split_done: got ack=%b aw=%0d w=%0d b=%0d unstable=%0d want 1 1 1 1 0",
               ACK0, aw_hs_cnt - a0, w_hs_cnt - w0, b_hs_cnt - b0, stab_err);
    end
    REQ0 = 1'b0;
    aw_delay = 0;
    cyc();
  endtask

  task automatic test_error_response();
    int n;
    checks++;
    if (ERR !== 1'b0) begin
      errors++;
      $display("FAIL err_pre: got %b want 0", ERR);
    end
    rresp_cfg = 2'b10; rd_fixed_en = 1'b1; rd_fixed = 32'hDEAD_0011;
    REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 32'h40;
    n = 0;
    while (ACK1 !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (ACK1 !== 1'b1 || RDATA1 !== 32'hDEAD_0011 || RESP1 !== 2'b10 || ERR !== 1'b1) begin
      errors++;
      $display("FAIL err_read: got ack=%b rdata=%h resp=%b err=%b want 1 dead0011 10 1",
               ACK1, RDATA1, RESP1, ERR);
    end
    REQ1 = 1'b0;
    rresp_cfg = 2'b00; rd_fixed_en = 1'b0;
    cyc();
    REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 32'h44; WDATA1 = 32'h5555_AAAA;
    n = 0;
    while (ACK1 !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (ACK1 !== 1'b1 || RESP1 !== 2'b00 || ERR !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got ack=%b resp=%b err=%b want 1 00 1", ACK1, RESP1, ERR);
    end
    REQ1 = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid_transfer();
    int n;
    logic ack_in_reset;
    ack_in_reset = 1'b0;
    b_hold = 1'b1;
    REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 32'hC; WDATA0 = 32'h0BAD_F00D;
    n = 0;
    while (M_AXI_BREADY !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (M_AXI_BREADY !== 1'b1) begin
      errors++;
      $display("FAIL rst_wresp: got BREADY=%b want 1", M_AXI_BREADY);
    end
    cyc();
    #2;
    tb_ARESETN = 1'b0;
    #1;
    checks++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
         ACK0, ACK1, ERR} !== 8'h00) begin
      errors++;
      $display("FAIL rst_async: got %b want 00000000", {M_AXI_AWVALID, M_AXI_WVALID,
               M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, ACK0, ACK1, ERR});
    end
    REQ0 = 1'b0;
    repeat (2) begin
      cyc();
      if (ACK0 !== 1'b0 || M_AXI_BREADY !== 1'b0) ack_in_reset = 1'b1;
    end
    checks++;
    if (ack_in_reset) begin
      errors++;
      $display("FAIL rst_hold: got activity during reset want none");
    end
    b_hold = 1'b0;
    tb_ARESETN = 1'b1;
    REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 32'h30;
    n = 0;
    while (ACK0 !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (n != 4 || RDATA0 !== rd_model(32'h30) || RESP0 !== 2'b00) begin
      errors++;
      $display("FAIL rst_regrant: got %0d cycles rdata=%h resp=%b want 4 %h 00", n, RDATA0,
               RESP0, rd_model(32'h30));
    end
    REQ0 = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    int n, k, ar0;
    logic [31:0] addrs [3];
    addrs[0] = 32'h100; addrs[1] = 32'h104; addrs[2] = 32'h108;
    ar0 = ar_hs_cnt;
    rnd = 1'b1;
    REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = addrs[0];
    k = 0; n = 0;
    while (k < 3 && n < 300) begin
      cyc();
      n++;
      checks++;
      if (M_AXI_ARVALID === 1'b1 && M_AXI_RREADY === 1'b1) begin
        errors++;
        $display("FAIL b2b_overlap: got ARVALID=1 with RREADY=1 want no overlap");
      end
      if (ACK1 === 1'b1) begin
        checks++;
        if (RDATA1 !== rd_model(addrs[k])) begin
          errors++;
          $display("FAIL b2b_rdata%0d: got %h want %h", k, RDATA1, rd_model(addrs[k]));
        end
        k++;
        if (k < 3) ADDR1 = addrs[k];
        else REQ1 = 1'b0;
      end
    end
    REQ1 = 1'b0;
    rnd = 1'b0;
    checks++;
    if (k != 3 || ar_hs_cnt - ar0 != 3) begin
      errors++;
      $display("FAIL b2b_count: got acks=%0d ar=%0d want 3 3", k, ar_hs_cnt - ar0);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_write();
    test_split_handshake();
    test_error_response();
    test_reset_mid_transfer();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
